// File: rtl/nios_handshake_debug_cmd_sync.sv
// nios_handshake_debug_cmd_sync
// System-clock side of the Nios II JTAG debug command path. Toggle-encoded
// update-IR / update-DR events arrive from the TCK domain and are
// synchronised into clk. Each update-DR captures the TCK shift register as
// a command, which is held under a valid/ready handshake and decoded into
// a one-hot take_action / take_no_action pulse when it is accepted.
//
// Build option: define DBG_CMD_FIFO_EN to replace the single command slot
// with a 4-entry first-word-fall-through FIFO of {cmd_ir, cmd_data}.
//
// SYNC_STAGES must lie in 2..4.
module nios_handshake_debug_cmd_sync #(
    parameter int DR_W        = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DR_W-1:0]         sr_in,
    input  logic [IR_W-1:0]         ir_in,
    input  logic                    uir_tgl,
    input  logic                    udr_tgl,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [IR_W-1:0]         cmd_ir,
    output logic [DR_W-1:0]         cmd_data,
    output logic [(1<<IR_W)-1:0]    take_action,
    output logic [(1<<IR_W)-1:0]    take_no_action,
    output logic [IR_W-1:0]         ir_q,
    output logic                    overrun,
    input  logic                    overrun_clr
);

    localparam int N = 1 << IR_W;
    localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);

    // ------------------------------------------------------------------
    // Toggle synchronisers, edge history and post-reset priming
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
    logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
    logic                   uir_hist_q, uir_hist_d;
    logic                   udr_hist_q, udr_hist_d;
    logic [2:0]             prime_q, prime_d;
    logic                   primed;
    logic                   uir_edge;
    logic                   udr_edge;

    // Shift the toggles through the sync chain and track the last stage
    always_comb begin
        uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], uir_tgl};
        udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], udr_tgl};
        uir_hist_d = uir_sync_q[SYNC_STAGES-1];
        udr_hist_d = udr_sync_q[SYNC_STAGES-1];
    end

    // Count up after reset; edges are ignored until the chain is refilled
    always_comb begin
        primed  = (prime_q == PRIME_DONE);
        prime_d = primed ? prime_q : prime_q + 3'd1;
    end

    // Edge detection, masked while priming so a toggle that was already
    // high at reset release is not mistaken for an event
    always_comb begin
        uir_edge = primed & (uir_sync_q[SYNC_STAGES-1] ^ uir_hist_q);
        udr_edge = primed & (udr_sync_q[SYNC_STAGES-1] ^ udr_hist_q);
    end

    // Synchroniser, history and prime-counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            uir_sync_q <= '0;
            udr_sync_q <= '0;
            uir_hist_q <= 1'b0;
            udr_hist_q <= 1'b0;
            prime_q    <= '0;
        end else begin
            uir_sync_q <= uir_sync_d;
            udr_sync_q <= udr_sync_d;
            uir_hist_q <= uir_hist_d;
            udr_hist_q <= udr_hist_d;
            prime_q    <= prime_d;
        end
    end

    // ------------------------------------------------------------------
    // Instruction register capture
    // ------------------------------------------------------------------
    logic [IR_W-1:0] ir_cap_q, ir_cap_d;

    // Capture ir_in on every update-IR event
    always_comb begin
        ir_cap_d = uir_edge ? ir_in : ir_cap_q;
    end

    // IR capture register
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_cap_q <= '0;
        end else begin
            ir_cap_q <= ir_cap_d;
        end
    end

    assign ir_q = ir_cap_q;

    // ------------------------------------------------------------------
    // Command storage: head of storage is what the consumer sees
    // ------------------------------------------------------------------
    logic            head_valid;
    logic [IR_W-1:0] head_ir;
    logic [DR_W-1:0] head_data;
    logic            pop;
    logic            push;
    logic            drop;

`ifdef DBG_CMD_FIFO_EN
    logic [IR_W-1:0] fifo_ir_q   [4];
    logic [IR_W-1:0] fifo_ir_d   [4];
    logic [DR_W-1:0] fifo_data_q [4];
    logic [DR_W-1:0] fifo_data_d [4];
    logic [1:0]      wr_ptr_q, wr_ptr_d;
    logic [1:0]      rd_ptr_q, rd_ptr_d;
    logic [2:0]      count_q, count_d;
    logic            full;

    // FIFO handshake: a pop in the same cycle frees room for a push when full
    always_comb begin
        full       = (count_q == 3'd4);
        head_valid = (count_q != 3'd0);
        head_ir    = fifo_ir_q[rd_ptr_q];
        head_data  = fifo_data_q[rd_ptr_q];
        pop        = head_valid & cmd_ready;
        push       = udr_edge & (~full | pop);
        drop       = udr_edge & full & ~pop;
    end

    // FIFO write, pointer and occupancy update
    always_comb begin
        fifo_ir_d   = fifo_ir_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + {2'b00, push} - {2'b00, pop};
        if (push) begin
            // Commands take the IR held before any update-IR in this cycle
            fifo_ir_d[wr_ptr_q]   = ir_cap_q;
            fifo_data_d[wr_ptr_q] = sr_in;
            wr_ptr_d              = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
    end

    // FIFO storage and pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                fifo_ir_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            fifo_ir_q   <= fifo_ir_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end
`else
    logic            slot_valid_q, slot_valid_d;
    logic [IR_W-1:0] slot_ir_q, slot_ir_d;
    logic [DR_W-1:0] slot_data_q, slot_data_d;

    // Single slot handshake: free when empty or being accepted this cycle
    always_comb begin
        head_valid = slot_valid_q;
        head_ir    = slot_ir_q;
        head_data  = slot_data_q;
        pop        = slot_valid_q & cmd_ready;
        push       = udr_edge & (~slot_valid_q | cmd_ready);
        drop       = udr_edge & slot_valid_q & ~cmd_ready;
    end

    // Load a new command or retire the accepted one
    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_ir_d    = slot_ir_q;
        slot_data_d  = slot_data_q;
        if (push) begin
            // Commands take the IR held before any update-IR in this cycle
            slot_valid_d = 1'b1;
            slot_ir_d    = ir_cap_q;
            slot_data_d  = sr_in;
        end else if (pop) begin
            slot_valid_d = 1'b0;
        end
    end

    // Command slot registers
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid_q <= 1'b0;
            slot_ir_q    <= '0;
            slot_data_q  <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_ir_q    <= slot_ir_d;
            slot_data_q  <= slot_data_d;
        end
    end
`endif

    assign cmd_valid = head_valid;
    assign cmd_ir    = head_ir;
    assign cmd_data  = head_data;

    // ------------------------------------------------------------------
    // Decode and overrun
    // ------------------------------------------------------------------
    logic [N-1:0] take_action_q, take_action_d;
    logic [N-1:0] take_no_action_q, take_no_action_d;
    logic         overrun_q, overrun_d;

    // One-hot decode of the command being accepted this cycle
    always_comb begin
        take_action_d    = '0;
        take_no_action_d = '0;
        if (pop) begin
            if (head_data[DR_W-1]) begin
                take_action_d[head_ir] = 1'b1;
            end else begin
                take_no_action_d[head_ir] = 1'b1;
            end
        end
    end

    // Sticky overrun; a drop in the same cycle wins over a clear
    always_comb begin
        if (drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Decode pulse and overrun registers
    always_ff @(posedge clk) begin
        if (reset) begin
            take_action_q    <= '0;
            take_no_action_q <= '0;
            overrun_q        <= 1'b0;
        end else begin
            take_action_q    <= take_action_d;
            take_no_action_q <= take_no_action_d;
            overrun_q        <= overrun_d;
        end
    end

    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;
    assign overrun        = overrun_q;

endmodule
